// File: rtl/alu_seq.sv
// Registered NZVC ALU with carry-chained ADC and shift-add MUL; 1-cycle latency, WIDTH+1 for MUL.
// Valid/ready in, valid/ready out; in_ready only in IDLE, results held until out_ready drains them.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       NZVC,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_ADC = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        count;

   logic [WIDTH-1:0]     b_op;
   logic                 cin;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_v;
   logic                 alu_c;

   logic [2*WIDTH-1:0]   acc_step;
   logic                 last_step;
   logic [WIDTH-1:0]     mul_res;
   logic                 mul_hi;

   assign in_ready = (state == IDLE);

   // SUB is A + ~B + 1 so the same adder gives carry = "no borrow".
   always_comb begin
      b_op = B;
      cin  = 1'b0;
      case (Sel)
         OP_SUB: begin
            b_op = ~B;
            cin  = 1'b1;
         end
         OP_ADC:  cin = NZVC[0];
         default: ;
      endcase
      sum = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
   end

   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      case (Sel)
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_NOT: alu_res = ~A;
         OP_ADD, OP_SUB, OP_ADC: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_comb begin
      acc_step  = mplier[0] ? (acc + mcand) : acc;
      last_step = (count == CW'(WIDTH - 1));
      mul_res   = acc_step[WIDTH-1:0];
      mul_hi    = |acc_step[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         Result    <= '0;
         NZVC      <= 4'b0000;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (Sel == OP_MUL) begin
                     mcand  <= {{WIDTH{1'b0}}, A};
                     mplier <= B;
                     acc    <= '0;
                     count  <= '0;
                     busy   <= 1'b1;
                     state  <= MUL;
                  end else begin
                     Result    <= alu_res;
                     NZVC      <= {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            MUL: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (last_step) begin
                  Result    <= mul_res;
                  NZVC      <= {mul_res[WIDTH-1], (mul_res == '0), mul_hi, mul_hi};
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU with NZVC flags.
- Width is generic and results/flags are registered behind a valid/ready handshake.
- Adds a persistent flag register, carry-chained add (ADC) and a multi-cycle shift-add multiplier.
- Sits between operand/opcode source (datapath control) and result sink (register file write-back).

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept operation this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Sel  input  3  opcode
out_valid  output  1  Result/NZVC valid
out_ready  input  1  sink accepts result
Result  output  WIDTH  registered result
NZVC  output  4  registered flags {N,Z,V,C} of last completed op
busy  output  1  multiply in progress

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): state=IDLE, Result=0, NZVC=4'b0000, out_valid=0, busy=0, in_ready=1 after release.
- Accept: transfer when in_valid && in_ready; A, B, Sel captured that edge.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT A; 100 ADD A+B; 101 SUB A+~B+1; 110 ADC A+B+C_flag; 111 MUL low WIDTH bits of A*B (unsigned).
- Flags, all ops: N=Result[WIDTH-1], Z=(Result==0).
- Logic ops: V=0, C=0.
- ADD/ADC: C=carry-out of bit WIDTH-1; V=signed overflow (operands same sign, result sign differs).
- SUB: C=carry-out (1 = no borrow, A>=B unsigned); V=(A,B signs differ and result sign != A sign).
- MUL: C=V=(upper WIDTH bits of full product != 0).
- ADC uses the C flag held in NZVC at the accept edge. After reset that flag is 0.
- States:
  - IDLE: in_ready=1. On accept of non-MUL op: Result/NZVC written at that edge, out_valid=1, go DONE (latency 1 cycle). On accept of MUL: load multiplicand/multiplier/accumulator (2*WIDTH), busy=1, count=0, go MUL.
  - MUL: one shift-add step per cycle. Exactly WIDTH cycles. On last step write Result/NZVC, busy=0, out_valid=1, go DONE. Total latency WIDTH+1 edges from accept to out_valid. in_ready=0.
  - DONE: out_valid=1, in_ready=0. When out_ready=1: out_valid drops next edge, go IDLE.
- No accept-and-drain in the same cycle: in_ready is derived from state only, not from out_ready. Max throughput is one op per 2 cycles.
- Result and NZVC hold their values after drain until the next completion. NZVC is never cleared except by reset.
- Inputs A/B/Sel are ignored outside accept edges. Changing them mid-MUL has no effect.
- Reset mid-MUL: operation aborted, no out_valid, NZVC=0.
- out_ready low in DONE: Result/NZVC/out_valid stable indefinitely.
- Sel X/unknown outside accept edges: no effect.

Test Plan:
- Reset then idle (WIDTH=8): rst_n low mid-cycle -> Result=0x00, NZVC=0000, out_valid=0, in_ready=1 immediately on async assert.
- ADD carry/overflow: A=0x7F, B=0x01, Sel=100 -> next edge Result=0x80, NZVC=1010. Then A=0xFF, B=0x01, ADD -> Result=0x00, NZVC=0101.
- ADC chain: after 0xFF+0x01 (C=1), ADC A=0x10, B=0x20 -> Result=0x31, C=0. Repeat ADC -> 0x30.
- SUB borrow: A=0x05, B=0x07, Sel=101 -> Result=0xFE, NZVC=1000. Then A=0x07, B=0x07 -> Result=0x00, NZVC=0101.
- MUL: A=0x12, B=0x10 -> busy=1 for 8 cycles, in_ready=0, out_valid at edge 9, Result=0x20, NZVC=0011. Also 0x0F*0x0F -> 0xE1, NZVC=1000.
- Backpressure/abort: hold out_ready=0 for 5 cycles after XOR (A=0xAA, B=0xAA) -> Result=0x00, NZVC=0100 stable, in_valid ignored. Separately assert rst_n low at MUL step 4 -> no out_valid, state IDLE, NZVC=0000.
